dp_sim_memory_ws: RTL and testbench
===================================

Name: dp_sim_memory_ws

Overview:
Dual-port, 32-bit word simulation memory with per-port wait-state insertion and a request/ready handshake.
It is the next-generation bench memory for core instruction and data ports. Each port runs its own access state machine, so fetch and load/store latencies can be stressed independently.
The block is simulation-only: $readmemh preload, no synthesis target.

Parameters:
MEM_ADDR_WIDTH, 8, word address width; depth = 2**MEM_ADDR_WIDTH words (default 1 KB).
A_WAIT_CYCLES, 0, wait states W inserted on port A per access (0..15).
B_WAIT_CYCLES, 0, wait states W inserted on port B per access (0..15).
INIT_FILE, "mem.hex", hex preload file; empty string means no preload (contents X).
MAX_EXTRA_WAIT, 3, upper bound of random extra wait states (used only with MEM_RANDOM_WAIT_EN).

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
a_addr  in  MEM_ADDR_WIDTH  port A word address
a_din  in  32  port A write data
a_wr  in  4  port A byte write enables; 4'b0 = read
a_enable  in  1  port A request valid
a_dout  out  32  port A read/write-back data; valid only while a_ready=1
a_ready  out  1  port A one-cycle completion pulse
b_addr, b_din, b_wr, b_enable, b_dout, b_ready: identical to port A, for port B

Behaviour:
- Reset (async assert, sampled release):
  - a_ready/b_ready = 0; a_dout/b_dout = 32'h0.
  - Both FSMs go to IDLE; wait counters = 0.
  - Memory contents are untouched by reset.
- Per-port FSM states:
  - IDLE: waiting for a request.
  - WAIT: counting down wait states.
  - RESP: ready high for one cycle.
- Acceptance:
  - A request is accepted on an edge where enable=1 and the state is IDLE or RESP (back-to-back allowed).
  - addr/din/wr are latched at acceptance; input changes during WAIT are ignored.
- Transitions:
  - IDLE/RESP + enable: if W=0 go to RESP, else go to WAIT with counter=W.
  - IDLE/RESP + !enable: go to IDLE.
  - WAIT: decrement the counter each edge; at counter=1 go to RESP.
- Latency:
  - Accept at edge N; the memory access executes at edge N+1+W; ready is high in the cycle following that edge.
  - W=0 gives 1-cycle latency and full throughput (one access per cycle).
- Data output:
  - Read (wr=0): dout = word at the latched address.
  - Write: enabled byte lanes are updated; dout = the resulting merged word.
  - dout = 32'h0 whenever ready=0 (never Z or X).
- Simultaneous same-address accesses on the same edge:
  - Both ports write: for each byte lane written by both, port B data wins; lanes written by only one port take that port's data.
  - One port reads while the other writes: the read returns the pre-write word (read-before-write).
- Reset mid-operation: any in-flight WAIT access is discarded, no write is committed, and no ready pulse is issued.
- Address range: the full 2**MEM_ADDR_WIDTH range is legal; there is no wrap logic.
- enable=0 while in RESP does not cancel the pulse already in progress.

Optional Feature:
MEM_RANDOM_WAIT_EN:
- Defined: the wait count per request is W + ($random % (MAX_EXTRA_WAIT+1)), taken as unsigned and drawn independently per port at acceptance.
- Not defined: the wait count is exactly W. The random logic and the MAX_EXTRA_WAIT usage are compiled out.

Test Plan:
- A_WAIT_CYCLES=0, B_WAIT_CYCLES=0; preload word 0x10 = 0xDEADBEEF; port A read 0x10 at edge N -> a_ready=1 and a_dout=0xDEADBEEF in the cycle after edge N+1; port B idle, so b_dout=0.
- A_WAIT_CYCLES=3; port A writes 0x12345678 with a_wr=4'b0101 to address 0x04 (prior contents 0xAABBCCDD) -> a_ready rises 4 edges after acceptance; a_dout=0xAA34CC78; a subsequent read returns 0xAA34CC78.
- Both ports write address 0x08 on the same edge (A: 0x11111111 with wr=4'b1111; B: 0x22222222 with wr=4'b0011) -> word becomes 0x11112222.
- Port A reads 0x08 while port B writes 0xCAFEF00D there on the same edge -> a_dout = old value; the next port A read returns 0xCAFEF00D.
- B_WAIT_CYCLES=2; assert rst one cycle after a port B write is accepted -> b_ready never pulses and the word is unchanged; after reset release a new request completes normally.
- Back-to-back: A_WAIT_CYCLES=0 and a_enable held high for 4 reads of addresses 0..3 -> a_ready high for 4 consecutive cycles with data in order.

Source files
------------

// File: rtl/dp_sim_memory_ws.sv
// ---------------------------------------------------------------------------
// dp_sim_memory_ws
// Dual-port 32-bit word simulation memory with per-port wait-state insertion
// and a request/ready handshake. Bench-only model, not intended for
// synthesis.
//
// Ports
//   clk                 clock, all state on rising edge
//   rst                 asynchronous active-high reset
//   a_addr / b_addr     word address
//   a_din  / b_din      write data
//   a_wr   / b_wr       byte write enables, 4'b0 = read
//   a_enable/b_enable   request valid
//   a_dout / b_dout     read or merged write-back data, 0 unless ready
//   a_ready/ b_ready    one-cycle completion pulse
//
// Optional feature macro: MEM_RANDOM_WAIT_EN
//   When defined, each accepted request waits W + random(0..MAX_EXTRA_WAIT)
//   cycles, drawn independently per port.
//
// Per-port FSM
//   state | meaning
//   IDLE  | waiting for a request
//   WAIT  | counting down wait states
//   RESP  | access executes on the next edge; ready/dout are registered
//         | from that edge; a new request may be accepted here
// ---------------------------------------------------------------------------
module dp_sim_memory_ws #(
    parameter int    MEM_ADDR_WIDTH = 8,
    parameter int    A_WAIT_CYCLES  = 0,
    parameter int    B_WAIT_CYCLES  = 0,
    parameter string INIT_FILE      = "mem.hex",
    parameter int    MAX_EXTRA_WAIT = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [MEM_ADDR_WIDTH-1:0] a_addr,
    input  logic [31:0]               a_din,
    input  logic [3:0]                a_wr,
    input  logic                      a_enable,
    output logic [31:0]               a_dout,
    output logic                      a_ready,
    input  logic [MEM_ADDR_WIDTH-1:0] b_addr,
    input  logic [31:0]               b_din,
    input  logic [3:0]                b_wr,
    input  logic                      b_enable,
    output logic [31:0]               b_dout,
    output logic                      b_ready
);

    localparam int DEPTH = 2 ** MEM_ADDR_WIDTH;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [7:0] A_WAIT = 8'(A_WAIT_CYCLES);
    localparam logic [7:0] B_WAIT = 8'(B_WAIT_CYCLES);

    logic [31:0] mem [DEPTH];

    logic [1:0]                a_state_q, a_state_d, b_state_q, b_state_d;
    logic [7:0]                a_cnt_q, a_cnt_d, b_cnt_q, b_cnt_d;
    logic [MEM_ADDR_WIDTH-1:0] a_addr_q, a_addr_d, b_addr_q, b_addr_d;
    logic [31:0]               a_din_q, a_din_d, b_din_q, b_din_d;
    logic [3:0]                a_wr_q, a_wr_d, b_wr_q, b_wr_d;
    logic [31:0]               a_dout_q, a_dout_d, b_dout_q, b_dout_d;
    logic                      a_ready_q, a_ready_d, b_ready_q, b_ready_d;

    logic [7:0]  a_wait, b_wait;
    logic        a_exec, b_exec, same_addr;
    logic [3:0]  a_wr_eff, b_wr_eff;
    logic [31:0] a_old, b_old, a_merged, b_merged;

`ifdef MEM_RANDOM_WAIT_EN
    logic [7:0] a_extra_q, b_extra_q;

    // Fresh draw every edge; the value present at acceptance is the one used.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_extra_q <= 8'd0;
            b_extra_q <= 8'd0;
        end else begin
            a_extra_q <= 8'($unsigned($random) % (MAX_EXTRA_WAIT + 1));
            b_extra_q <= 8'($unsigned($random) % (MAX_EXTRA_WAIT + 1));
        end
    end

    assign a_wait = A_WAIT + a_extra_q;
    assign b_wait = B_WAIT + b_extra_q;
`else
    assign a_wait = A_WAIT;
    assign b_wait = B_WAIT;
`endif

    // Port A access FSM
    always_comb begin
        a_state_d = a_state_q;
        a_cnt_d   = a_cnt_q;
        a_addr_d  = a_addr_q;
        a_din_d   = a_din_q;
        a_wr_d    = a_wr_q;
        case (a_state_q)
            ST_IDLE, ST_RESP: begin
                if (a_enable) begin
                    a_addr_d = a_addr;
                    a_din_d  = a_din;
                    a_wr_d   = a_wr;
                    if (a_wait == 8'd0) begin
                        a_state_d = ST_RESP;
                        a_cnt_d   = 8'd0;
                    end else begin
                        a_state_d = ST_WAIT;
                        a_cnt_d   = a_wait;
                    end
                end else begin
                    a_state_d = ST_IDLE;
                    a_cnt_d   = 8'd0;
                end
            end
            ST_WAIT: begin
                if (a_cnt_q == 8'd1) begin
                    a_state_d = ST_RESP;
                    a_cnt_d   = 8'd0;
                end else begin
                    a_cnt_d = a_cnt_q - 8'd1;
                end
            end
            default: begin
                a_state_d = ST_IDLE;
                a_cnt_d   = 8'd0;
            end
        endcase
    end

    // Port B access FSM
    always_comb begin
        b_state_d = b_state_q;
        b_cnt_d   = b_cnt_q;
        b_addr_d  = b_addr_q;
        b_din_d   = b_din_q;
        b_wr_d    = b_wr_q;
        case (b_state_q)
            ST_IDLE, ST_RESP: begin
                if (b_enable) begin
                    b_addr_d = b_addr;
                    b_din_d  = b_din;
                    b_wr_d   = b_wr;
                    if (b_wait == 8'd0) begin
                        b_state_d = ST_RESP;
                        b_cnt_d   = 8'd0;
                    end else begin
                        b_state_d = ST_WAIT;
                        b_cnt_d   = b_wait;
                    end
                end else begin
                    b_state_d = ST_IDLE;
                    b_cnt_d   = 8'd0;
                end
            end
            ST_WAIT: begin
                if (b_cnt_q == 8'd1) begin
                    b_state_d = ST_RESP;
                    b_cnt_d   = 8'd0;
                end else begin
                    b_cnt_d = b_cnt_q - 8'd1;
                end
            end
            default: begin
                b_state_d = ST_IDLE;
                b_cnt_d   = 8'd0;
            end
        endcase
    end

    // Access datapath. Both ports see the pre-edge word, so a read racing a
    // write to the same address returns the old value. When both write the
    // same word, B's lanes override A's and both ports report the final word.
    assign a_exec    = (a_state_q == ST_RESP);
    assign b_exec    = (b_state_q == ST_RESP);
    assign a_wr_eff  = a_exec ? a_wr_q : 4'b0000;
    assign b_wr_eff  = b_exec ? b_wr_q : 4'b0000;
    assign same_addr = (a_addr_q == b_addr_q);
    assign a_old     = mem[a_addr_q];
    assign b_old     = mem[b_addr_q];

    always_comb begin
        a_merged = a_old;
        b_merged = b_old;
        for (int i = 0; i < 4; i++) begin
            if (a_wr_eff[i])              a_merged[8*i +: 8] = a_din_q[8*i +: 8];
            if (same_addr && b_wr_eff[i]) a_merged[8*i +: 8] = b_din_q[8*i +: 8];
            if (same_addr && a_wr_eff[i]) b_merged[8*i +: 8] = a_din_q[8*i +: 8];
            if (b_wr_eff[i])              b_merged[8*i +: 8] = b_din_q[8*i +: 8];
        end
    end

    always_comb begin
        a_ready_d = a_exec;
        b_ready_d = b_exec;
        a_dout_d  = 32'h0;
        b_dout_d  = 32'h0;
        if (a_exec) a_dout_d = (a_wr_q == 4'b0000) ? a_old : a_merged;
        if (b_exec) b_dout_d = (b_wr_q == 4'b0000) ? b_old : b_merged;
    end

    // Same-address double writes store identical merged words, so the
    // order of these two assignments does not matter.
    always_ff @(posedge clk) begin
        if (a_exec && (a_wr_q != 4'b0000)) mem[a_addr_q] <= a_merged;
        if (b_exec && (b_wr_q != 4'b0000)) mem[b_addr_q] <= b_merged;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_state_q <= ST_IDLE;
            a_cnt_q   <= 8'd0;
            a_addr_q  <= '0;
            a_din_q   <= 32'h0;
            a_wr_q    <= 4'b0000;
            a_dout_q  <= 32'h0;
            a_ready_q <= 1'b0;
            b_state_q <= ST_IDLE;
            b_cnt_q   <= 8'd0;
            b_addr_q  <= '0;
            b_din_q   <= 32'h0;
            b_wr_q    <= 4'b0000;
            b_dout_q  <= 32'h0;
            b_ready_q <= 1'b0;
        end else begin
            a_state_q <= a_state_d;
            a_cnt_q   <= a_cnt_d;
            a_addr_q  <= a_addr_d;
            a_din_q   <= a_din_d;
            a_wr_q    <= a_wr_d;
            a_dout_q  <= a_dout_d;
            a_ready_q <= a_ready_d;
            b_state_q <= b_state_d;
            b_cnt_q   <= b_cnt_d;
            b_addr_q  <= b_addr_d;
            b_din_q   <= b_din_d;
            b_wr_q    <= b_wr_d;
            b_dout_q  <= b_dout_d;
            b_ready_q <= b_ready_d;
        end
    end

    assign a_dout  = a_dout_q;
    assign a_ready = a_ready_q;
    assign b_dout  = b_dout_q;
    assign b_ready = b_ready_q;

endmodule

// File: tb/tb_dp_sim_memory_ws.sv
// ---------------------------------------------------------------------------
// tb_dp_sim_memory_ws
// Two instances: u_dut0 (A/B wait 0/0) and u_dut1 (A/B wait 3/2).
// A reference model keeps a word array per instance and schedules each
// accepted request to execute 1+W edges after acceptance; every cycle both
// ports of both instances are compared against it.
// ---------------------------------------------------------------------------
module tb_dp_sim_memory_ws;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        en_s   [2][2];
    logic [7:0]  addr_s [2][2];
    logic [31:0] din_s  [2][2];
    logic [3:0]  wr_s   [2][2];
    logic [31:0] dout_s [2][2];
    logic        rdy_s  [2][2];

    dp_sim_memory_ws #(
        .MEM_ADDR_WIDTH(8), .A_WAIT_CYCLES(0), .B_WAIT_CYCLES(0),
        .INIT_FILE(""), .MAX_EXTRA_WAIT(3)
    ) u_dut0 (
        .clk(clk), .rst(rst),
        .a_addr(addr_s[0][0]), .a_din(din_s[0][0]), .a_wr(wr_s[0][0]),
        .a_enable(en_s[0][0]), .a_dout(dout_s[0][0]), .a_ready(rdy_s[0][0]),
        .b_addr(addr_s[0][1]), .b_din(din_s[0][1]), .b_wr(wr_s[0][1]),
        .b_enable(en_s[0][1]), .b_dout(dout_s[0][1]), .b_ready(rdy_s[0][1])
    );

    dp_sim_memory_ws #(
        .MEM_ADDR_WIDTH(8), .A_WAIT_CYCLES(3), .B_WAIT_CYCLES(2),
        .INIT_FILE(""), .MAX_EXTRA_WAIT(3)
    ) u_dut1 (
        .clk(clk), .rst(rst),
        .a_addr(addr_s[1][0]), .a_din(din_s[1][0]), .a_wr(wr_s[1][0]),
        .a_enable(en_s[1][0]), .a_dout(dout_s[1][0]), .a_ready(rdy_s[1][0]),
        .b_addr(addr_s[1][1]), .b_din(din_s[1][1]), .b_wr(wr_s[1][1]),
        .b_enable(en_s[1][1]), .b_dout(dout_s[1][1]), .b_ready(rdy_s[1][1])
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Reference model state
    logic [31:0] mem_m  [2][256];
    int          free_e [2][2];
    bit          pv     [2][2][32];
    int          pe     [2][2][32];
    logic [7:0]  pa     [2][2][32];
    logic [31:0] pdn    [2][2][32];
    logic [3:0]  pw     [2][2][32];

    // Observation log
    int          n_rdy    [2][2];
    logic [31:0] last_do  [2][2];
    int          last_cyc [2][2];
    int          log_c [$];
    logic [31:0] log_d [$];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int wait_of(input int d, input int p);
        if (d == 0) return 0;
        return (p == 0) ? 3 : 2;
    endfunction

    function automatic bit port_free(input int d, input int p);
        return (cyc + 1) >= free_e[d][p];
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] w);
        logic [31:0] r;
        r = old_w;
        for (int i = 0; i < 4; i++)
            if (w[i]) r[8*i +: 8] = new_w[8*i +: 8];
        return r;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++)
            for (int p = 0; p < 2; p++) begin
                free_e[d][p] = 0;
                for (int s = 0; s < 32; s++) pv[d][p][s] = 1'b0;
            end
    endtask

    task automatic clear_en();
        for (int d = 0; d < 2; d++)
            for (int p = 0; p < 2; p++) begin
                en_s[d][p]   = 1'b0;
                addr_s[d][p] = 8'h0;
                din_s[d][p]  = 32'h0;
                wr_s[d][p]   = 4'h0;
            end
    endtask

    // Drive an accepted request and schedule it in the model.
    task automatic put(input int d, input int p, input logic [7:0] a, input logic [31:0] dn,
                       input logic [3:0] w, output int e);
        int ex;
        int s;
        en_s[d][p]   = 1'b1;
        addr_s[d][p] = a;
        din_s[d][p]  = dn;
        wr_s[d][p]   = w;
        e  = cyc + 1;
        ex = e + 1 + wait_of(d, p);
        s  = ex % 32;
        pv[d][p][s]  = 1'b1;
        pe[d][p][s]  = ex;
        pa[d][p][s]  = a;
        pdn[d][p][s] = dn;
        pw[d][p][s]  = w;
        free_e[d][p] = e + wait_of(d, p) + 1;
    endtask

    task automatic go(input int d,
                      input bit ea, input logic [7:0] aa, input logic [31:0] da, input logic [3:0] wa,
                      input bit eb, input logic [7:0] ab, input logic [31:0] db, input logic [3:0] wb,
                      output int e);
        bit ok;
        ok = 1'b0;
        e  = 0;
        for (int t = 0; t < 40 && !ok; t++) begin
            @(negedge clk);
            clear_en();
            if ((!ea || port_free(d, 0)) && (!eb || port_free(d, 1))) begin
                if (ea) put(d, 0, aa, da, wa, e);
                if (eb) put(d, 1, ab, db, wb, e);
                ok = 1'b1;
            end
        end
        check_val("go_timeout", {31'h0, ok}, 32'h1);
    endtask

    task automatic settle(input int n);
        repeat (n) begin
            @(negedge clk);
            clear_en();
        end
    endtask

    // Model execution and per-cycle comparison
    bit          hit  [2];
    bit          e_rd [2];
    logic [31:0] e_do [2];
    int          slot;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            slot = cyc % 32;
            for (int p = 0; p < 2; p++) begin
                hit[p]  = pv[d][p][slot] && (pe[d][p][slot] == cyc);
                e_rd[p] = hit[p];
                e_do[p] = 32'h0;
                if (hit[p] && pw[d][p][slot] == 4'h0) e_do[p] = mem_m[d][pa[d][p][slot]];
            end
            for (int p = 0; p < 2; p++)
                if (hit[p] && pw[d][p][slot] != 4'h0)
                    mem_m[d][pa[d][p][slot]] = merge(mem_m[d][pa[d][p][slot]],
                                                     pdn[d][p][slot], pw[d][p][slot]);
            for (int p = 0; p < 2; p++) begin
                if (hit[p] && pw[d][p][slot] != 4'h0) e_do[p] = mem_m[d][pa[d][p][slot]];
                if (hit[p]) pv[d][p][slot] = 1'b0;
                check_val($sformatf("d%0d%s_ready", d, p ? "b" : "a"), {31'h0, rdy_s[d][p]},
                          {31'h0, e_rd[p]});
                check_val($sformatf("d%0d%s_dout", d, p ? "b" : "a"), dout_s[d][p], e_do[p]);
                if (rdy_s[d][p] === 1'b1) begin
                    n_rdy[d][p]++;
                    last_do[d][p]  = dout_s[d][p];
                    last_cyc[d][p] = cyc;
                    if (d == 0 && p == 0) begin
                        log_c.push_back(cyc);
                        log_d.push_back(dout_s[d][p]);
                    end
                end
            end
        end
    end

    int          e;
    int          nb;
    bit          ren;
    logic [7:0]  ra;
    logic [31:0] rd;
    logic [3:0]  rw;

    initial begin
        for (int d = 0; d < 2; d++)
            for (int p = 0; p < 2; p++) begin
                n_rdy[d][p]    = 0;
                last_do[d][p]  = 32'h0;
                last_cyc[d][p] = 0;
            end
        rst = 1'b1;
        clear_en();
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Preload a working window of both memories through port A
        for (int d = 0; d < 2; d++)
            for (int a = 0; a < 16; a++)
                go(d, 1, 8'(a), $urandom, 4'hf, 0, 8'h0, 32'h0, 4'h0, e);
        settle(6);

        // Zero-wait read of a known word
        go(0, 0, 8'h0, 32'h0, 4'h0, 1, 8'h10, 32'hDEADBEEF, 4'hf, e);
        go(0, 1, 8'h10, 32'h0, 4'h0, 0, 8'h0, 32'h0, 4'h0, e);
        settle(4);
        check_val("tp1_data", last_do[0][0], 32'hDEADBEEF);
        check_val("tp1_latency", 32'(last_cyc[0][0] - e), 32'd1);

        // Partial write with three wait states
        go(1, 1, 8'h04, 32'hAABBCCDD, 4'hf, 0, 8'h0, 32'h0, 4'h0, e);
        go(1, 1, 8'h04, 32'h12345678, 4'b0101, 0, 8'h0, 32'h0, 4'h0, e);
        settle(8);
        check_val("tp2_wdata", last_do[1][0], 32'hAA34CC78);
        check_val("tp2_latency", 32'(last_cyc[1][0] - e), 32'd4);
        go(1, 1, 8'h04, 32'h0, 4'h0, 0, 8'h0, 32'h0, 4'h0, e);
        settle(8);
        check_val("tp2_readback", last_do[1][0], 32'hAA34CC78);

        // Same-edge double write: B lanes win
        go(0, 1, 8'h08, 32'h11111111, 4'hf, 1, 8'h08, 32'h22222222, 4'b0011, e);
        go(0, 1, 8'h08, 32'h0, 4'h0, 0, 8'h0, 32'h0, 4'h0, e);
        settle(3);
        check_val("tp3_collide", last_do[0][0], 32'h11112222);

        // Read racing a write returns the old word
        go(0, 1, 8'h08, 32'h0, 4'h0, 1, 8'h08, 32'hCAFEF00D, 4'hf, e);
        settle(3);
        check_val("tp4_rbw_old", last_do[0][0], 32'h11112222);
        go(0, 1, 8'h08, 32'h0, 4'h0, 0, 8'h0, 32'h0, 4'h0, e);
        settle(3);
        check_val("tp4_rbw_new", last_do[0][0], 32'hCAFEF00D);

        // Reset during a port B wait discards the write and the pulse
        go(1, 0, 8'h0, 32'h0, 4'h0, 1, 8'h20, 32'h01020304, 4'hf, e);
        settle(6);
        nb = n_rdy[1][1];
        go(1, 0, 8'h0, 32'h0, 4'h0, 1, 8'h20, 32'hFFFFFFFF, 4'hf, e);
        @(negedge clk);
        clear_en();
        rst = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        settle(6);
        check_val("tp5_no_ready", 32'(n_rdy[1][1]), 32'(nb));
        go(1, 0, 8'h0, 32'h0, 4'h0, 1, 8'h20, 32'h0, 4'h0, e);
        settle(6);
        check_val("tp5_word_kept", last_do[1][1], 32'h01020304);
        check_val("tp5_ready_after", 32'(n_rdy[1][1]), 32'(nb + 1));

        // Back-to-back zero-wait reads
        go(0, 1, 8'h00, 32'h100, 4'hf, 1, 8'h01, 32'h101, 4'hf, e);
        go(0, 1, 8'h02, 32'h102, 4'hf, 1, 8'h03, 32'h103, 4'hf, e);
        settle(3);
        log_c.delete();
        log_d.delete();
        for (int i = 0; i < 4; i++)
            go(0, 1, 8'(i), 32'h0, 4'h0, 0, 8'h0, 32'h0, 4'h0, e);
        settle(3);
        check_val("tp6_count", 32'(log_d.size()), 32'd4);
        if (log_d.size() == 4)
            for (int i = 0; i < 4; i++) begin
                check_val($sformatf("tp6_data%0d", i), log_d[i], 32'h100 + 32'(i));
                check_val($sformatf("tp6_cycle%0d", i), 32'(log_c[i] - log_c[0]), 32'(i));
            end

        // Random traffic on both instances; enables while busy must be ignored
        for (int t = 0; t < 600; t++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++)
                for (int p = 0; p < 2; p++) begin
                    ren = 1'($urandom_range(0, 1));
                    ra  = 8'($urandom_range(0, 15));
                    rd  = $urandom;
                    rw  = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
                    if (ren && port_free(d, p)) begin
                        put(d, p, ra, rd, rw, e);
                    end else begin
                        en_s[d][p]   = ren;
                        addr_s[d][p] = ra;
                        din_s[d][p]  = rd;
                        wr_s[d][p]   = rw;
                    end
                end
        end
        settle(25);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
